lcd_bf_reader: RTL and testbench
================================

// Module: lcd_bf_reader
// PURPOSE
//  Read-side companion of the 1602A 4-bit write driver: runs an HD44780 4-bit read cycle
//  (RS=0, RW=1) to fetch busy flag (BF) and address counter (AC) from the LCD.
//  Optional poll mode repeats reads until BF=0 or a poll limit expires.
//  Sits beside the write driver; an external mux hands it the LCD pins while bus_own=1.
// PARAMETERS
//  T_AS       1     clk cycles RS/RW setup before E rises (>=40ns @20MHz)
//  T_EH       10    clk cycles E held high per nibble (>=450ns); valid range 2..255
//  T_EL       10    clk cycles E held low after each nibble (>=500ns); valid range 1..255
//  MAX_POLLS  4000  max reads per poll-mode transaction before timeout; range 1..65535
// PORTS
//  clk          in   1  system clock, 20MHz
//  rst_n        in   1  asynchronous active-low reset
//  start        in   1  request a read transaction; sampled only in IDLE
//  poll_mode    in   1  sampled with start: 1 = repeat until BF=0, 0 = single read
//  lcd_data_in  in   4  LCD DB7..DB4 as seen by FPGA (tristate handled outside)
//  lcd_ctrl     out  3  {RS,RW,E} to LCD when bus_own=1
//  bus_own      out  1  1 while the reader owns the LCD pins (any state but IDLE)
//  busy         out  1  1 from start acceptance until the cycle after rd_valid
//  rd_valid     out  1  single-cycle strobe: rd_bf/rd_ac/rd_timeout are valid
//  rd_bf        out  1  busy flag from last completed read
//  rd_ac        out  7  address counter from last completed read
//  rd_timeout   out  1  1 with rd_valid when poll limit hit with BF still 1
// BEHAVIOUR
//  Reset (async assert, sync deassert): state=IDLE, lcd_ctrl=3'b010, bus_own=0, busy=0,
//   rd_valid=0, rd_bf=0, rd_ac=0, rd_timeout=0, all counters 0. E drops on reset assertion.
//  States: IDLE -> SETUP -> E1_HI -> E1_LO -> E2_HI -> E2_LO -> (SETUP | DONE) -> IDLE.
//  IDLE: lcd_ctrl=3'b010. start=1 at edge k: latch poll_mode, poll_cnt=0, go SETUP.
//  SETUP: RS=0, RW=1, E=0 for T_AS cycles.
//  E1_HI/E2_HI: E=1 for T_EH cycles; lcd_data_in sampled on the final E-high cycle
//   (E1 -> hi nibble {BF,AC[6:4]}, E2 -> lo nibble AC[3:0]). E falls the next cycle.
//  E1_LO/E2_LO: E=0, RW=1 for T_EL cycles.
//  End of E2_LO: poll_cnt++. If latched poll_mode=1, BF=1 and poll_cnt<MAX_POLLS -> SETUP
//   (RW stays 1, bus_own stays 1). Otherwise -> DONE.
//  DONE (1 cycle): rd_valid=1, rd_bf/rd_ac updated from the sampled nibbles,
//   rd_timeout = poll_mode & BF; next state IDLE. rd_bf/rd_ac hold until next DONE.
//  Single-read latency: rd_valid high exactly 1+T_AS+2*(T_EH+T_EL) cycles after the start
//   edge (42 with defaults). Each extra poll adds T_AS+2*(T_EH+T_EL).
//  start outside IDLE is ignored (no queueing); start in the IDLE cycle after DONE is accepted.
//  poll_mode changes after acceptance have no effect.
//  RS is 0 in every state; RW never 0; data bus is never driven by this block.
//  Timers: 8-bit phase counter reloaded on each state entry; 16-bit poll_cnt saturates.
// TESTING
//  1) start, poll_mode=0, data hi=4'h3 lo=4'hA -> rd_valid @ start+42, rd_bf=0, rd_ac=7'h3A.
//  2) poll_mode=1, BF reads 1,1,0 (AC=7'h05) -> 3 read cycles, one rd_valid, rd_timeout=0.
//  3) MAX_POLLS=3, BF stuck 1 -> exactly 3 reads, rd_valid with rd_timeout=1, rd_bf=1.
//  4) start pulses during E1_HI and DONE -> ignored; start in following IDLE cycle accepted.
//  5) rst_n low mid E2_HI -> E=0 same cycle, lcd_ctrl=3'b010, rd_valid never pulses.
//  6) Check E high width=T_EH and low width=T_EL every nibble; RW=1 throughout.

Source files
------------

// File: rtl/lcd_bf_reader.sv
// HD44780 4-bit read-cycle engine: fetches busy flag and address counter from a 1602A LCD.
// In poll mode it keeps reading until BF clears or the poll limit is reached.
// Owns the LCD pins (bus_own) from start acceptance until the result is handed back.
module lcd_bf_reader #(
  parameter int unsigned T_AS      = 1,
  parameter int unsigned T_EH      = 10,
  parameter int unsigned T_EL      = 10,
  parameter int unsigned MAX_POLLS = 4000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       poll_mode,
  input  logic [3:0] lcd_data_in,
  output logic [2:0] lcd_ctrl,
  output logic       bus_own,
  output logic       busy,
  output logic       rd_valid,
  output logic       rd_bf,
  output logic [6:0] rd_ac,
  output logic       rd_timeout
);

  typedef enum logic [2:0] {
    IDLE, SETUP, E1_HI, E1_LO, E2_HI, E2_LO, DONE
  } state_t;

  // Phase timers count down to zero, so each one is loaded with its duration minus one.
  localparam logic [7:0]  AsLoad   = 8'(T_AS - 1);
  localparam logic [7:0]  EhLoad   = 8'(T_EH - 1);
  localparam logic [7:0]  ElLoad   = 8'(T_EL - 1);
  localparam logic [15:0] MaxPolls = 16'(MAX_POLLS);

  // {RS,RW,E}: RS is always 0 and RW always 1, only E toggles.
  localparam logic [2:0] CtrlEHigh = 3'b011;
  localparam logic [2:0] CtrlELow  = 3'b010;

  state_t      state_q;
  logic [7:0]  phaseCnt_q;
  logic [15:0] pollCnt_q;
  logic [15:0] pollCnt_d;
  logic        pollMode_q;
  logic [3:0]  hiNib_q;
  logic [3:0]  loNib_q;
  logic [2:0]  ctrl_q;
  logic        busOwn_q;
  logic        busy_q;
  logic        rdValid_q;
  logic        rdBf_q;
  logic [6:0]  rdAc_q;
  logic        rdTimeout_q;

  // Read count after the read that is finishing now; it saturates rather than wrapping.
  always_comb begin
    pollCnt_d = pollCnt_q;
    if (pollCnt_q != 16'hFFFF) begin
      pollCnt_d = pollCnt_q + 16'd1;
    end
  end

  // Read-cycle sequencer; pin controls and result fields are registered with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phaseCnt_q  <= 8'd0;
      pollCnt_q   <= 16'd0;
      pollMode_q  <= 1'b0;
      hiNib_q     <= 4'd0;
      loNib_q     <= 4'd0;
      ctrl_q      <= CtrlELow;
      busOwn_q    <= 1'b0;
      busy_q      <= 1'b0;
      rdValid_q   <= 1'b0;
      rdBf_q      <= 1'b0;
      rdAc_q      <= 7'd0;
      rdTimeout_q <= 1'b0;
    end else begin
      rdValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ctrl_q <= CtrlELow;
          if (start) begin
            pollMode_q <= poll_mode;
            pollCnt_q  <= 16'd0;
            phaseCnt_q <= AsLoad;
            busOwn_q   <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SETUP;
          end else begin
            busOwn_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        end
        SETUP: begin
          if (phaseCnt_q == 8'd0) begin
            phaseCnt_q <= EhLoad;
            ctrl_q     <= CtrlEHigh;
            state_q    <= E1_HI;
          end else begin
            phaseCnt_q <= phaseCnt_q - 8'd1;
          end
        end
        E1_HI: begin
          if (phaseCnt_q == 8'd0) begin
            hiNib_q    <= lcd_data_in;
            phaseCnt_q <= ElLoad;
            ctrl_q     <= CtrlELow;
            state_q    <= E1_LO;
          end else begin
            phaseCnt_q <= phaseCnt_q - 8'd1;
          end
        end
        E1_LO: begin
          if (phaseCnt_q == 8'd0) begin
            phaseCnt_q <= EhLoad;
            ctrl_q     <= CtrlEHigh;
            state_q    <= E2_HI;
          end else begin
            phaseCnt_q <= phaseCnt_q - 8'd1;
          end
        end
        E2_HI: begin
          if (phaseCnt_q == 8'd0) begin
            loNib_q    <= lcd_data_in;
            phaseCnt_q <= ElLoad;
            ctrl_q     <= CtrlELow;
            state_q    <= E2_LO;
          end else begin
            phaseCnt_q <= phaseCnt_q - 8'd1;
          end
        end
        E2_LO: begin
          if (phaseCnt_q == 8'd0) begin
            pollCnt_q <= pollCnt_d;
            if (pollMode_q && hiNib_q[3] && (pollCnt_d < MaxPolls)) begin
              phaseCnt_q <= AsLoad;
              state_q    <= SETUP;
            end else begin
              phaseCnt_q <= 8'd0;
              state_q    <= DONE;
            end
          end else begin
            phaseCnt_q <= phaseCnt_q - 8'd1;
          end
        end
        DONE: begin
          rdValid_q   <= 1'b1;
          rdBf_q      <= hiNib_q[3];
          rdAc_q      <= {hiNib_q[2:0], loNib_q};
          rdTimeout_q <= pollMode_q & hiNib_q[3];
          busOwn_q    <= 1'b0;
          ctrl_q      <= CtrlELow;
          state_q     <= IDLE;
        end
        default: begin
          ctrl_q   <= CtrlELow;
          busOwn_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign lcd_ctrl   = ctrl_q;
  assign bus_own    = busOwn_q;
  assign busy       = busy_q;
  assign rd_valid   = rdValid_q;
  assign rd_bf      = rdBf_q;
  assign rd_ac      = rdAc_q;
  assign rd_timeout = rdTimeout_q;

endmodule

// File: tb/tb_lcd_bf_reader.sv
// Testbench for lcd_bf_reader: emulates the LCD answering read cycles and compares each
// transaction against a model built from read counts, latency arithmetic and response tables.
module tb_lcd_bf_reader;

  localparam int TAS  = 1;
  localparam int TEH  = 10;
  localparam int TEL  = 10;
  localparam int MAXP = 3;
  localparam int L    = 1 + TAS + 2 * (TEH + TEL);
  localparam int P    = TAS + 2 * (TEH + TEL);

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       poll_mode;
  logic [3:0] lcd_data_in;
  logic [2:0] lcd_ctrl;
  logic       bus_own;
  logic       busy;
  logic       rd_valid;
  logic       rd_bf;
  logic [6:0] rd_ac;
  logic       rd_timeout;

  int totalChecks = 0;
  int badChecks   = 0;

  // LCD response table: hi nibble {BF,AC[6:4]} and lo nibble AC[3:0] for each read.
  logic [3:0] rhi [4];
  logic [3:0] rlo [4];

  int pulseIdx   = 0;
  int hiCnt      = 0;
  int loCnt      = 0;
  int lastReads  = 0;
  int validCount = 0;
  logic prevE    = 1'b0;

  lcd_bf_reader #(
    .T_AS(TAS), .T_EH(TEH), .T_EL(TEL), .MAX_POLLS(MAXP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .poll_mode(poll_mode),
    .lcd_data_in(lcd_data_in),
    .lcd_ctrl(lcd_ctrl),
    .bus_own(bus_own),
    .busy(busy),
    .rd_valid(rd_valid),
    .rd_bf(rd_bf),
    .rd_ac(rd_ac),
    .rd_timeout(rd_timeout)
  );

  // 20 MHz clock.
  initial begin
    clk = 1'b0;
    forever #25 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // LCD emulation: drives the requested nibble on each E pulse and checks pin timing.
  always @(posedge clk) begin
    #1;
    checkOutput("rs_rw", {30'd0, lcd_ctrl[2:1]}, 32'd1);
    if (rd_valid) validCount++;
    if (!bus_own) begin
      if (pulseIdx > 0) lastReads = pulseIdx / 2;
      pulseIdx = 0;
      hiCnt    = 0;
      loCnt    = 0;
      prevE    = 1'b0;
    end else if (lcd_ctrl[0] && !prevE) begin
      pulseIdx++;
      if (pulseIdx > 1) begin
        checkOutput("e_low_width", loCnt, (pulseIdx % 2 == 0) ? TEL : TEL + TAS);
      end
      hiCnt = 1;
      if (((pulseIdx - 1) / 2) < 4) begin
        lcd_data_in = (pulseIdx % 2 == 1) ? rhi[(pulseIdx - 1) / 2] : rlo[(pulseIdx - 1) / 2];
      end else begin
        lcd_data_in = 4'h0;
      end
      prevE = 1'b1;
    end else if (lcd_ctrl[0]) begin
      hiCnt++;
    end else if (prevE) begin
      checkOutput("e_high_width", hiCnt, TEH);
      loCnt = 1;
      prevE = 1'b0;
    end else if (pulseIdx > 0) begin
      loCnt++;
    end
  end

  // One transaction from start to result, checked against the read-count/latency model.
  task automatic applyStimulus(input logic pm);
    int reads;
    int expLat;
    int m;
    int vc0;
    logic [3:0] hiLast;
    logic [3:0] loLast;
    reads = 0;
    for (int i = 0; i < 4; i++) begin
      reads = i + 1;
      if (!pm || !rhi[i][3] || reads >= MAXP) break;
    end
    expLat = L + (reads - 1) * P;
    hiLast = rhi[reads - 1];
    loLast = rlo[reads - 1];
    vc0 = validCount;
    start = 1'b1;
    poll_mode = pm;
    @(negedge clk);
    start = 1'b0;
    poll_mode = ~pm;
    checkOutput("busy_accept", busy, 1);
    checkOutput("bus_own_accept", bus_own, 1);
    m = 0;
    while (!rd_valid && m < expLat + 20) begin
      @(negedge clk);
      m++;
    end
    checkOutput("latency", m, expLat);
    checkOutput("reads", lastReads, reads);
    checkOutput("rd_bf", rd_bf, hiLast[3]);
    checkOutput("rd_ac", rd_ac, {hiLast[2:0], loLast});
    checkOutput("rd_timeout", rd_timeout, pm & hiLast[3]);
    checkOutput("busy_at_valid", busy, 1);
    @(negedge clk);
    checkOutput("valid_single", rd_valid, 0);
    checkOutput("busy_end", busy, 0);
    checkOutput("valid_count", validCount - vc0, 1);
  endtask

  initial begin
    int m;
    int vc0;
    int firstV;
    int secondV;
    rst_n = 1'b0;
    start = 1'b0;
    poll_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rhi[i] = 4'h0;
      rlo[i] = 4'h0;
    end
    repeat (3) @(negedge clk);
    checkOutput("rst_ctrl", lcd_ctrl, 3'b010);
    checkOutput("rst_bus_own", bus_own, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid", rd_valid, 0);
    checkOutput("rst_bf", rd_bf, 0);
    checkOutput("rst_ac", rd_ac, 0);
    checkOutput("rst_timeout", rd_timeout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single read hi=3 lo=A");
    rhi[0] = 4'h3; rlo[0] = 4'hA;
    applyStimulus(1'b0);

    $display("[TB] poll BF 1,1,0 AC=05");
    rhi[0] = 4'h8; rlo[0] = 4'h1;
    rhi[1] = 4'h9; rlo[1] = 4'h2;
    rhi[2] = 4'h0; rlo[2] = 4'h5;
    applyStimulus(1'b1);

    $display("[TB] poll BF stuck at 1");
    rhi[0] = 4'hF; rlo[0] = 4'h3;
    rhi[1] = 4'hC; rlo[1] = 4'h7;
    rhi[2] = 4'hA; rlo[2] = 4'hE;
    rhi[3] = 4'h8; rlo[3] = 4'h0;
    applyStimulus(1'b1);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 4; i++) begin
        rhi[i] = {($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, 3'($urandom)};
        rlo[i] = 4'($urandom);
      end
      applyStimulus(1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("[TB] start pulses outside IDLE");
    rhi[0] = 4'h5; rlo[0] = 4'hC;
    vc0 = validCount;
    firstV = -1;
    secondV = -1;
    start = 1'b1;
    poll_mode = 1'b0;
    @(negedge clk);
    m = 0;
    while (m < 2 * L + 10) begin
      start = (m == 5 || m == L - 1 || m == L);
      @(negedge clk);
      m++;
      if (rd_valid) begin
        if (firstV < 0) firstV = m;
        else if (secondV < 0) secondV = m;
      end
    end
    start = 1'b0;
    checkOutput("ignore_first_lat", firstV, L);
    checkOutput("accept_after_done", secondV, 2 * L + 1);
    checkOutput("ignore_count", validCount - vc0, 2);
    checkOutput("ignore_ac", rd_ac, 7'h5C);
    checkOutput("ignore_busy", busy, 0);

    $display("[TB] reset during E2 high");
    rhi[0] = 4'h2; rlo[0] = 4'h6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    checkOutput("e_before_rst", lcd_ctrl[0], 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_ctrl", lcd_ctrl, 3'b010);
    checkOutput("rst_mid_bus_own", bus_own, 0);
    checkOutput("rst_mid_busy", busy, 0);
    vc0 = validCount;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * L) @(negedge clk);
    checkOutput("rst_no_valid", validCount - vc0, 0);
    checkOutput("rst_ac_cleared", rd_ac, 0);
    checkOutput("rst_idle_ctrl", lcd_ctrl, 3'b010);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
